axi_lite_dmem: RTL and testbench

AXI_LITE_DMEM -- requirements
Module: axi_lite_dmem

---
 rtl/axi_lite_dmem_if.sv | 43 ++++
 rtl/axi_lite_dmem.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_lite_dmem.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_dmem_if.sv
// Shared AXI-Lite types and the AXI-Lite bus interface used by the data memory.
// The package holds the address/data/strobe/response types plus the two response codes.
package axi_lite_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi_lite_if;
    import axi_lite_pkg::*;

    logic  awvalid;
    logic  awready;
    addr_t awaddr;
    logic  wvalid;
    logic  wready;
    data_t wdata;
    strb_t wstrb;
    logic  bvalid;
    logic  bready;
    resp_t bresp;
    logic  arvalid;
    logic  arready;
    addr_t araddr;
    logic  rvalid;
    logic  rready;
    data_t rdata;
    resp_t rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_dmem.sv
// AXI-Lite slave backed by a DEPTH x 32-bit word memory with byte strobes.
// Independent write and read FSMs; every handshake/valid output is a flop.
module axi_lite_dmem #(
    parameter int DEPTH     = 32,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic         aclk,
    input  logic         areset_n,
    axi_lite_if.slave    s_axi_lite
);
    import axi_lite_pkg::*;

    localparam int    IDX_W      = $clog2(DEPTH);
    localparam addr_t ADDR_LIMIT = addr_t'(DEPTH * 4);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    function automatic data_t merge_bytes(input data_t old_word, input data_t new_word,
                                          input strb_t strb);
        data_t merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

    // Full-width compare so addresses past the array never alias onto low words.
    function automatic logic addr_in_range(input addr_t a);
        return (a < ADDR_LIMIT);
    endfunction

    function automatic idx_t word_index(input addr_t a);
        return a[IDX_W+1:2];
    endfunction

    wstate_t wstate_r;
    addr_t   awaddr_r;
    data_t   wdata_r;
    strb_t   wstrb_r;
    logic    awready_r;
    logic    wready_r;
    logic    bvalid_r;
    resp_t   bresp_r;

    rstate_t rstate_r;
    logic    arready_r;
    logic    rvalid_r;
    data_t   rdata_r;
    resp_t   rresp_r;

    data_t   mem_r [DEPTH];

    logic    aw_hs_s;
    logic    w_hs_s;
    logic    ar_hs_s;
    logic    wr_commit_s;
    logic    wr_ok_s;
    addr_t   wr_addr_s;
    data_t   wr_data_s;
    strb_t   wr_strb_s;

    assign aw_hs_s = s_axi_lite.awvalid & awready_r;
    assign w_hs_s  = s_axi_lite.wvalid  & wready_r;
    assign ar_hs_s = s_axi_lite.arvalid & arready_r;

    // Write commit: the edge that completes both AW and W, using bypassed or latched halves.
    always_comb begin
        wr_addr_s   = aw_hs_s ? s_axi_lite.awaddr : awaddr_r;
        wr_data_s   = w_hs_s  ? s_axi_lite.wdata  : wdata_r;
        wr_strb_s   = w_hs_s  ? s_axi_lite.wstrb  : wstrb_r;
        wr_ok_s     = addr_in_range(wr_addr_s);
        wr_commit_s = 1'b0;
        case (wstate_r)
            W_IDLE:   wr_commit_s = aw_hs_s & w_hs_s;
            W_GOT_AW: wr_commit_s = w_hs_s;
            W_GOT_W:  wr_commit_s = aw_hs_s;
            W_RESP:   wr_commit_s = 1'b0;
            default:  wr_commit_s = 1'b0;
        endcase
    end

    // Write FSM; readies are set from the next state so they stay pure flops.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wstate_r  <= W_IDLE;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                awaddr_r <= s_axi_lite.awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= s_axi_lite.wdata;
                wstrb_r <= s_axi_lite.wstrb;
            end
            if (wr_commit_s) begin
                wstate_r  <= W_RESP;
                awready_r <= 1'b0;
                wready_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wstate_r)
                    W_IDLE: begin
                        if (aw_hs_s) begin
                            wstate_r  <= W_GOT_AW;
                            awready_r <= 1'b0;
                            wready_r  <= 1'b1;
                        end else if (w_hs_s) begin
                            wstate_r  <= W_GOT_W;
                            awready_r <= 1'b1;
                            wready_r  <= 1'b0;
                        end else begin
                            awready_r <= 1'b1;
                            wready_r  <= 1'b1;
                        end
                    end
                    W_GOT_AW: begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                    end
                    W_GOT_W: begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b0;
                    end
                    W_RESP: begin
                        if (s_axi_lite.bready) begin
                            wstate_r  <= W_IDLE;
                            bvalid_r  <= 1'b0;
                            awready_r <= 1'b1;
                            wready_r  <= 1'b1;
                        end
                    end
                    default: begin
                        wstate_r  <= W_IDLE;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    generate
        if (INIT_ZERO) begin : g_mem_clear
            // Memory array with reset clear; out-of-range writes are dropped.
            always_ff @(posedge aclk or negedge areset_n) begin
                if (!areset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_r[i] <= 32'h0;
                    end
                end else if (wr_commit_s && wr_ok_s) begin
                    mem_r[word_index(wr_addr_s)] <= merge_bytes(mem_r[word_index(wr_addr_s)],
                                                                wr_data_s, wr_strb_s);
                end
            end
        end else begin : g_mem_keep
            // Memory array whose contents survive reset.
            always_ff @(posedge aclk) begin
                if (areset_n && wr_commit_s && wr_ok_s) begin
                    mem_r[word_index(wr_addr_s)] <= merge_bytes(mem_r[word_index(wr_addr_s)],
                                                                wr_data_s, wr_strb_s);
                end
            end
        end
    endgenerate

    // Read FSM; rdata samples the pre-update word when a write lands on the same edge.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rstate_r  <= R_DATA;
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        if (addr_in_range(s_axi_lite.araddr)) begin
                            rdata_r <= mem_r[word_index(s_axi_lite.araddr)];
                            rresp_r <= RESP_OKAY;
                        end else begin
                            rdata_r <= 32'h0;
                            rresp_r <= RESP_SLVERR;
                        end
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_lite.rready) begin
                        rstate_r  <= R_IDLE;
                        arready_r <= 1'b1;
                        rvalid_r  <= 1'b0;
                    end
                end
                default: begin
                    rstate_r  <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_lite.awready = awready_r;
    assign s_axi_lite.wready  = wready_r;
    assign s_axi_lite.bvalid  = bvalid_r;
    assign s_axi_lite.bresp   = bresp_r;
    assign s_axi_lite.arready = arready_r;
    assign s_axi_lite.rvalid  = rvalid_r;
    assign s_axi_lite.rdata   = rdata_r;
    assign s_axi_lite.rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_dmem.sv
// Directed bench for axi_lite_dmem: transaction-level model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_axi_lite_dmem;
    import axi_lite_pkg::*;

    localparam int DEPTH = 32;
    localparam int IW    = $clog2(DEPTH);

    logic aclk     = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_if bus ();

    axi_lite_dmem #(.DEPTH(DEPTH), .INIT_ZERO(1'b1)) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .s_axi_lite (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] mem_m [DEPTH];
    bit          rdy_on, aw_have, w_have, b_pend, r_pend;
    logic [31:0] aw_a, w_d, rdata_m;
    logic [3:0]  w_s;
    logic [1:0]  bresp_m, rresp_m;
    bit          e_awr, e_wr, e_arr, aw_hs, w_hs, ar_hs;

    always @(negedge aclk) begin
        if (!areset_n) begin
            chk("rst_awready", bus.awready, 0);
            chk("rst_wready",  bus.wready,  0);
            chk("rst_arready", bus.arready, 0);
            chk("rst_bvalid",  bus.bvalid,  0);
            chk("rst_rvalid",  bus.rvalid,  0);
            chk("rst_bresp",   bus.bresp,   0);
            chk("rst_rresp",   bus.rresp,   0);
            chk("rst_rdata",   bus.rdata,   0);
            rdy_on = 0; aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        end else begin
            e_awr = rdy_on && !aw_have && !b_pend;
            e_wr  = rdy_on && !w_have && !b_pend;
            e_arr = rdy_on && !r_pend;
            chk("awready", bus.awready, e_awr);
            chk("wready",  bus.wready,  e_wr);
            chk("arready", bus.arready, e_arr);
            chk("bvalid",  bus.bvalid,  b_pend);
            chk("rvalid",  bus.rvalid,  r_pend);
            if (b_pend) chk("bresp", bus.bresp, bresp_m);
            if (r_pend) begin
                chk("rdata", bus.rdata, rdata_m);
                chk("rresp", bus.rresp, rresp_m);
            end
            // Predict what the next rising edge does.
            aw_hs = bus.awvalid && e_awr;
            w_hs  = bus.wvalid && e_wr;
            ar_hs = bus.arvalid && e_arr;
            if (r_pend && bus.rready) r_pend = 0;
            if (ar_hs) begin
                r_pend = 1;
                if (bus.araddr < 32'(DEPTH * 4)) begin
                    rdata_m = mem_m[bus.araddr[IW+1:2]];
                    rresp_m = 2'b00;
                end else begin
                    rdata_m = 32'h0;
                    rresp_m = 2'b10;
                end
            end
            if (b_pend && bus.bready) b_pend = 0;
            if (aw_hs) begin aw_have = 1; aw_a = bus.awaddr; end
            if (w_hs)  begin w_have = 1; w_d = bus.wdata; w_s = bus.wstrb; end
            if (aw_have && w_have) begin
                if (aw_a < 32'(DEPTH * 4)) begin
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) mem_m[aw_a[IW+1:2]][8*b +: 8] = w_d[8*b +: 8];
                    bresp_m = 2'b00;
                end else begin
                    bresp_m = 2'b10;
                end
                b_pend = 1; aw_have = 0; w_have = 0;
            end
            rdy_on = 1;
        end
    end

    // ---------------- stimulus helpers (inputs change at posedge+1) ----------------
    task automatic send_aw(input logic [31:0] a);
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.awready) begin
                @(posedge aclk); #1; bus.awvalid = 1'b0; return;
            end
        end
        chk("aw_handshake_timeout", bus.awready, 1);
        @(posedge aclk); #1; bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.wready) begin
                @(posedge aclk); #1; bus.wvalid = 1'b0; return;
            end
        end
        chk("w_handshake_timeout", bus.wready, 1);
        @(posedge aclk); #1; bus.wvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold, input logic [1:0] exp_resp, input bit chk_lat);
        int n;
        n = 0;
        bus.bready = 1'b0;
        @(negedge aclk);
        while (!bus.bvalid && n < 20) begin n++; @(negedge aclk); end
        chk("bvalid_seen", bus.bvalid, 1);
        if (chk_lat) chk("b_latency", n, 0);
        chk("bresp_lit", bus.bresp, exp_resp);
        for (int h = 0; h < hold; h++) begin @(posedge aclk); #1; end
        if (hold > 0) begin
            chk("bvalid_held", bus.bvalid, 1);
            chk("awready_held", bus.awready, 0);
            chk("wready_held", bus.wready, 0);
            chk("bresp_held", bus.bresp, exp_resp);
        end
        @(posedge aclk); #1; bus.bready = 1'b1;
        @(posedge aclk); #1; bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(0, exp_resp, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_r);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.arready) break;
        end
        chk("ar_handshake", bus.arready, 1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(negedge aclk);
        chk("r_latency_rvalid", bus.rvalid, 1);
        chk("rdata_lit", bus.rdata, exp_d);
        chk("rresp_lit", bus.rresp, exp_r);
        @(posedge aclk); #1; bus.rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = 32'h0;
        bus.wvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = 32'h0; bus.rready = 1'b0;

        // Reset and ready release on the first edge after deassertion.
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_lit_awready", bus.awready, 0);
        areset_n = 1'b1;
        @(negedge aclk);
        chk("pre_edge_awready", bus.awready, 0);
        @(posedge aclk); #1;
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_wready",  bus.wready,  1);
        chk("post_rst_arready", bus.arready, 1);

        // Full-word write then read back.
        do_write(32'h4, 32'hdeadbeef, 4'hF, 2'b00);
        do_read(32'h4, 32'hdeadbeef, 2'b00);

        // Low half-word strobe.
        do_write(32'h4, 32'h12345678, 4'b0011, 2'b00);
        do_read(32'h4, 32'hdead5678, 2'b00);

        // W ahead of AW.
        send_w(32'ha5a5a5a5, 4'hF);
        chk("wready_after_w", bus.wready, 0);
        repeat (2) begin @(posedge aclk); #1; end
        chk("bvalid_before_aw", bus.bvalid, 0);
        send_aw(32'h8);
        wait_b(0, 2'b00, 1'b1);
        do_read(32'h8, 32'ha5a5a5a5, 2'b00);

        // Empty strobe leaves the word alone; unaligned address uses word 2.
        do_write(32'hB, 32'hffffffff, 4'h0, 2'b00);
        do_read(32'hA, 32'ha5a5a5a5, 2'b00);

        // Out of range, and the top in-range word.
        do_write(32'h80, 32'h11111111, 4'hF, 2'b10);
        do_read(32'h80, 32'h0, 2'b10);
        do_read(32'h0, 32'h0, 2'b00);
        do_write(32'h7C, 32'hcafef00d, 4'hF, 2'b00);
        do_read(32'h7C, 32'hcafef00d, 2'b00);

        // Stalled B channel with a concurrent read.
        fork
            begin
                fork
                    send_aw(32'h10);
                    send_w(32'h0badf00d, 4'hF);
                join
                wait_b(5, 2'b00, 1'b1);
            end
            begin
                @(posedge aclk); #1;
                do_read(32'h4, 32'hdead5678, 2'b00);
            end
        join
        do_read(32'h10, 32'h0badf00d, 2'b00);

        // Read collides with the commit edge on the same word: old value returned.
        fork
            send_aw(32'h14);
            send_w(32'h77777777, 4'hF);
            do_read(32'h14, 32'h0, 2'b00);
        join
        wait_b(0, 2'b00, 1'b0);
        do_read(32'h14, 32'h77777777, 2'b00);

        // Reset while only AW has been accepted.
        send_aw(32'hC);
        chk("got_aw_awready", bus.awready, 0);
        areset_n = 1'b0;
        #1;
        chk("async_awready", bus.awready, 0);
        chk("async_wready",  bus.wready,  0);
        chk("async_arready", bus.arready, 0);
        chk("async_bvalid",  bus.bvalid,  0);
        chk("async_rvalid",  bus.rvalid,  0);
        @(posedge aclk); #1;
        areset_n = 1'b1;
        @(posedge aclk); #1;
        chk("rel_awready", bus.awready, 1);
        chk("rel_wready",  bus.wready,  1);
        chk("rel_arready", bus.arready, 1);
        do_read(32'hC, 32'h0, 2'b00);
        do_read(32'h4, 32'h0, 2'b00);

        repeat (2) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
